frame_strobe_writer: RTL and testbench

- Write-side driver for per-tile frame-latch configuration memories: consumes a 32-bit configuration word stream and produces the FrameData row bus plus a one-hot FrameStrobe pulse for a single column.
- Sits between the bitstream source (UART/bit-bang loader) and the fabric column strobe fan-out.
- Sequences data setup, strobe and hold so that the level-sensitive frame latches capture clean data.

---
 rtl/frame_cfg_pkg.sv | 21 ++
 rtl/frame_index_decoder.sv | 18 +
 rtl/frame_strobe_writer.sv | 140 ++++++++++++++
 tb/tb_frame_strobe_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared constants and state encoding for the frame strobe writer and future readback logic.
package frame_cfg_pkg;

  localparam logic [15:0] HeaderMagic = 16'hFAB0;

  localparam int MagicHi = 31;
  localparam int MagicLo = 16;
  localparam int ColHi   = 15;
  localparam int ColLo   = 8;
  localparam int FrameHi = 7;
  localparam int FrameLo = 0;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } frameState_e;

endpackage

// File: rtl/frame_index_decoder.sv
// Combinational frame index to one-hot strobe; an out-of-range index or a low enable yields all zero.
module frame_index_decoder #(
  parameter int Width    = 20,
  parameter int IdxWidth = 5
) (
  input  logic [IdxWidth-1:0] frameIndex,
  input  logic                enable,
  output logic [Width-1:0]    strobe
);

  always_comb begin
    strobe = '0;
    for (int i = 0; i < Width; i++) begin
      strobe[i] = enable && (frameIndex == IdxWidth'(i));
    end
  end

endmodule

// File: rtl/frame_strobe_writer.sv
// Header/data word stream to FrameData + one-hot FrameStrobe sequencer for frame latches.
// Optional running XOR of data words enabled by FRAME_STROBE_WRITER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for a header word; bad headers set Error and are dropped
// DATA   | waiting for the data word; it is registered into FrameData on acceptance
// SETUP  | one cycle of data setup before the strobe
// STROBE | selected FrameStrobe bit high for StrobeCycles cycles
// HOLD   | one cycle of data hold; frame counted on exit
module frame_strobe_writer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int MaxCols         = 16,
  parameter int StrobeCycles    = 2
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] WordData,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [$clog2(MaxCols)-1:0] ColAddr,
  output logic                       Busy,
  output logic                       Error,
  output logic [15:0]                FramesWritten,
  output logic [FrameBitsPerRow-1:0] Checksum
);

  localparam int ColW   = $clog2(MaxCols);
  localparam int FrameW = $clog2(MaxFramesPerCol);
  localparam int CntW   = 4;

  frameState_e state, stateNext;

  logic [CntW-1:0]            strobeCnt;
  logic [FrameW-1:0]          frameIdx;
  logic [MaxFramesPerCol-1:0] strobeNext;
  logic                       hdrOk;
  logic                       loadHdr;
  logic                       loadData;
  logic                       hdrErr;
  logic                       frameDone;

  assign hdrOk = (WordData[MagicHi:MagicLo] == HeaderMagic)
              && (int'(WordData[ColHi:ColLo]) < MaxCols)
              && (int'(WordData[FrameHi:FrameLo]) < MaxFramesPerCol);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    WordReady = 1'b0;
    loadHdr   = 1'b0;
    loadData  = 1'b0;
    hdrErr    = 1'b0;
    frameDone = 1'b0;
    case (state)
      IDLE: begin
        WordReady = 1'b1;
        if (WordValid) begin
          if (hdrOk) begin
            loadHdr   = 1'b1;
            stateNext = DATA;
          end else begin
            hdrErr = 1'b1;
          end
        end
      end
      DATA: begin
        WordReady = 1'b1;
        if (WordValid) begin
          loadData  = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP:  stateNext = STROBE;
      STROBE: if (strobeCnt == '0) stateNext = HOLD;
      HOLD: begin
        frameDone = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Strobe is registered from the next state so the latch enables never glitch.
  frame_index_decoder #(
    .Width    (MaxFramesPerCol),
    .IdxWidth (FrameW)
  ) uDecoder (
    .frameIndex (frameIdx),
    .enable     (stateNext == STROBE),
    .strobe     (strobeNext)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData     <= '0;
      FrameStrobe   <= '0;
      ColAddr       <= '0;
      frameIdx      <= '0;
      strobeCnt     <= '0;
      Error         <= 1'b0;
      FramesWritten <= '0;
    end else begin
      FrameStrobe <= strobeNext;
      if (loadHdr) begin
        ColAddr  <= WordData[ColLo +: ColW];
        frameIdx <= WordData[FrameLo +: FrameW];
      end
      if (loadData) FrameData <= WordData;
      if (state == SETUP)                           strobeCnt <= CntW'(StrobeCycles - 1);
      else if (state == STROBE && strobeCnt != '0) strobeCnt <= strobeCnt - 1'b1;
      if (hdrErr)    Error         <= 1'b1;
      if (frameDone) FramesWritten <= FramesWritten + 16'd1;
    end
  end

`ifdef FRAME_STROBE_WRITER_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] checksumReg;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)       checksumReg <= '0;
    else if (loadData) checksumReg <= checksumReg ^ WordData;
  end

  assign Checksum = checksumReg;
`else
  assign Checksum = '0;
`endif

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Randomized scoreboard bench for frame_strobe_writer; expectations follow FRAME_STROBE_WRITER_CHECKSUM_EN.
module tb_frame_strobe_writer;

  localparam int StrobeCycles = 2;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [31:0] WordData;
  logic        WordValid;
  logic        WordReady;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [3:0]  ColAddr;
  logic        Busy;
  logic        Error;
  logic [15:0] FramesWritten;
  logic [31:0] Checksum;

  frame_strobe_writer dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .WordData      (WordData),
    .WordValid     (WordValid),
    .WordReady     (WordReady),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .ColAddr       (ColAddr),
    .Busy          (Busy),
    .Error         (Error),
    .FramesWritten (FramesWritten),
    .Checksum      (Checksum)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  col;
    int          frame;
    logic [31:0] data;
    logic [31:0] cks;
    logic [15:0] fw;
    logic        err;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic        expectData = 1'b0;
  logic [3:0]  mCol = '0;
  int          mFrame = 0;
  logic [31:0] mCks = '0;
  logic [15:0] mFw = '0;
  logic        mErr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelAccept(input logic [31:0] w);
    rec_t r;
    if (!expectData) begin
      if (w[31:16] == 16'hFAB0 && w[15:8] < 8'd16 && w[7:0] < 8'd20) begin
        expectData = 1'b1;
        mCol   = w[11:8];
        mFrame = int'(w[7:0]);
      end else begin
        mErr = 1'b1;
      end
    end else begin
      expectData = 1'b0;
`ifdef FRAME_STROBE_WRITER_CHECKSUM_EN
      mCks = mCks ^ w;
`endif
      mFw = mFw + 16'd1;
      r.col = mCol; r.frame = mFrame; r.data = w; r.cks = mCks; r.fw = mFw; r.err = mErr;
      q.push_back(r);
    end
  endtask

  task automatic sendWord(input logic [31:0] w);
    int n = 0;
    @(negedge CLK);
    WordData  = w;
    WordValid = 1'b1;
    while (!WordReady && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!WordReady) begin
      chk("ready_timeout", {31'd0, WordReady}, 32'd1);
      WordValid = 1'b0;
    end else begin
      @(posedge CLK);
      modelAccept(w);
    end
  endtask

  task automatic idleGap(input int cycles);
    @(negedge CLK);
    WordValid = 1'b0;
    repeat (cycles) @(negedge CLK);
  endtask

  // monitor state
  int   runLen = 0;
  logic fwPending = 1'b0;
  rec_t cur;
  logic [19:0] prevStrobe = '0;

  always @(negedge CLK) begin
    if (!resetn) begin
      runLen = 0;
      fwPending = 1'b0;
      prevStrobe = '0;
    end else begin
      if (fwPending) begin
        chk("frames_written", {16'd0, FramesWritten}, {16'd0, cur.fw});
        fwPending = 1'b0;
      end
      if (FrameStrobe != '0) begin
        chk("ready_low_in_strobe", {31'd0, WordReady}, 32'd0);
        if (runLen == 0) begin
          if (q.size() == 0) begin
            chk("unexpected_strobe", {12'd0, FrameStrobe}, 32'd0);
          end else begin
            cur = q.pop_front();
            chk("strobe_onehot", {12'd0, FrameStrobe}, {12'd0, 20'd1 << cur.frame});
            chk("col_addr", {28'd0, ColAddr}, {28'd0, cur.col});
            chk("frame_data", FrameData, cur.data);
            chk("error_flag", {31'd0, Error}, {31'd0, cur.err});
            chk("checksum", Checksum, cur.cks);
          end
        end else begin
          chk("strobe_stable", {12'd0, FrameStrobe}, {12'd0, prevStrobe});
          chk("data_stable", FrameData, cur.data);
        end
        runLen++;
      end else if (runLen != 0) begin
        chk("strobe_length", runLen, StrobeCycles);
        chk("ready_low_in_hold", {31'd0, WordReady}, 32'd0);
        chk("hold_data", FrameData, cur.data);
        fwPending = 1'b1;
        runLen = 0;
      end
      prevStrobe = FrameStrobe;
    end
  end

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || runLen != 0 || fwPending) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_data"}, FrameData, 32'd0);
    chk({tag, "_strobe"}, {12'd0, FrameStrobe}, 32'd0);
    chk({tag, "_col"}, {28'd0, ColAddr}, 32'd0);
    chk({tag, "_err"}, {31'd0, Error}, 32'd0);
    chk({tag, "_fw"}, {16'd0, FramesWritten}, 32'd0);
    chk({tag, "_cks"}, Checksum, 32'd0);
    chk({tag, "_ready"}, {31'd0, WordReady}, 32'd1);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  task automatic modelReset();
    expectData = 1'b0;
    mCks = '0;
    mFw = '0;
    mErr = 1'b0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int n;
    resetn = 1'b0;
    WordValid = 1'b0;
    WordData = '0;
    repeat (3) @(posedge CLK);
    #1 checkResetValues("reset");
    @(negedge CLK) resetn = 1'b1;

    // basic frame
    sendWord(32'hFAB0_0305);
    sendWord(32'hDEAD_BEEF);
    drain();

    // frame index out of range, then a good frame
    sendWord(32'hFAB0_0314);
    @(negedge CLK);
    chk("bad_frame_error", {31'd0, Error}, 32'd1);
    chk("bad_frame_idle", {31'd0, Busy}, 32'd0);
    sendWord(32'hFAB0_0A13);
    sendWord(32'h1234_5678);
    drain();

    // bad magic
    sendWord(32'hFAB1_0102);
    @(negedge CLK);
    chk("bad_magic_idle", {31'd0, Busy}, 32'd0);
    chk("bad_magic_fw", {16'd0, FramesWritten}, {16'd0, mFw});

    // randomized mix; WordValid usually stays high through busy phases
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        w = {16'hFAB0, 4'd0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 19))};
        sendWord(w);
        if ($urandom_range(0, 4) == 0) idleGap($urandom_range(1, 3));
        sendWord($urandom);
      end else begin
        case ($urandom_range(0, 2))
          0:       w = {16'hFAB0 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
          1:       w = {16'hFAB0, 8'($urandom_range(16, 255)), 8'($urandom_range(0, 19))};
          default: w = {16'hFAB0, 8'($urandom_range(0, 15)), 8'($urandom_range(20, 255))};
        endcase
        sendWord(w);
      end
      if ($urandom_range(0, 2) == 0) idleGap($urandom_range(0, 2));
    end
    drain();
    chk("final_error", {31'd0, Error}, {31'd0, mErr});
    chk("final_fw", {16'd0, FramesWritten}, {16'd0, mFw});

    // reset asserted while strobing
    sendWord(32'hFAB0_0201);
    sendWord(32'hCAFE_F00D);
    n = 0;
    while (FrameStrobe == '0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("strobe_seen", {31'd0, FrameStrobe != '0}, 32'd1);
    #2 resetn = 1'b0;
    WordValid = 1'b0;
    #1 checkResetValues("midreset");
    modelReset();
    repeat (2) @(posedge CLK);
    #3 resetn = 1'b1;

    // checksum accumulation across two frames
    sendWord(32'hFAB0_0000);
    sendWord(32'h0000_00FF);
    sendWord(32'hFAB0_0F13);
    sendWord(32'h0000_0F0F);
    idleGap(1);
    drain();
`ifdef FRAME_STROBE_WRITER_CHECKSUM_EN
    chk("checksum_final", Checksum, 32'h0000_0FF0);
`else
    chk("checksum_final", Checksum, 32'h0000_0000);
`endif
    chk("post_reset_fw", {16'd0, FramesWritten}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
